// File: rtl/wam_pkg.sv
// -----------------------------------------------------------------------------
// wam_pkg
// Shared definitions for the Whac-A-Mole round controller: FSM state
// encodings, LFSR seed and tap mask, hole count, and a popcount helper.
// -----------------------------------------------------------------------------
package wam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } wam_state_e;

    localparam int         NUM_HOLES = 8;
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // x^8 + x^6 + x^5 + x^4 + 1, shift-left form: feedback from bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/wam_lfsr.sv
// -----------------------------------------------------------------------------
// wam_lfsr
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), synchronously reset
// to the seed. Advances every clock regardless of game state. The maximal-
// length polynomial and non-zero seed keep it out of the all-zero lock-up.
// Ports:
//   clk_19    in   game clock
//   rst       in   synchronous active-high reset (loads seed)
//   hole_idx  out  low three LFSR bits, used as the spawn candidate hole
// -----------------------------------------------------------------------------
module wam_lfsr
    import wam_pkg::*;
(
    input  logic       clk_19,
    input  logic       rst,
    output logic [2:0] hole_idx
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk_19) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign hole_idx = lfsr_q[2:0];

endmodule

// File: rtl/wam_mole_ctl.sv
// -----------------------------------------------------------------------------
// wam_mole_ctl
// Whac-A-Mole round controller. Sequences a round, spawns moles into eight
// holes from an LFSR, retires them on expiry or effective hit, and keeps the
// round's score and miss counts (both saturating at 255).
//
// Optional feature macro: WAM_SPEEDUP_EN
//   defined     : spawn lifetime = max(LIFE_TICKS - score[7:2], LIFE_MIN)
//   not defined : spawn lifetime = LIFE_TICKS
//
// Ports:
//   clk_19  in   game clock (sole clock)
//   rst     in   synchronous active-high reset
//   start   in   level; starts a round when sampled high in IDLE or OVER
//   hit     in   [7:0] effective-hit vector, one bit per hole
//   holes   out  [7:0] lit holes
//   score   out  [7:0] hits this round
//   miss    out  [7:0] expired moles this round
//   busy    out  high while in RUN
//   over    out  high while in OVER
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | after reset; holes dark, waiting for start
// RUN   | round in progress; spawning, expiring, scoring
// OVER  | round finished; holes dark, final score/miss held
// -----------------------------------------------------------------------------
module wam_mole_ctl
    import wam_pkg::*;
#(
    parameter int LIFE_TICKS  = 24,
    parameter int LIFE_MIN    = 4,
    parameter int SPAWN_TICKS = 8,
    parameter int GAME_TICKS  = 1024,
    parameter int MAX_MOLES   = 3
) (
    input  logic       clk_19,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] hit,
    output logic [7:0] holes,
    output logic [7:0] score,
    output logic [7:0] miss,
    output logic       busy,
    output logic       over
);

    localparam int GAME_W  = $clog2(GAME_TICKS + 1);
    localparam int SPAWN_W = $clog2(SPAWN_TICKS + 1);
    localparam int LIFE_W  = $clog2(LIFE_TICKS + 1);

    wam_state_e          state_q, state_d;
    logic [GAME_W-1:0]   game_q, game_d;
    logic [SPAWN_W-1:0]  spawn_q, spawn_d;
    logic [LIFE_W-1:0]   life_q [NUM_HOLES];
    logic [LIFE_W-1:0]   life_d [NUM_HOLES];
    logic [7:0]          holes_q, holes_d;
    logic [7:0]          score_q, score_d;
    logic [7:0]          miss_q, miss_d;
    logic                busy_q, busy_d;
    logic                over_q, over_d;

    logic [2:0]          hole_idx;
    logic [LIFE_W-1:0]   life_load;
    logic [7:0]          hit_eff;
    logic [7:0]          expire;
    logic [7:0]          spawn_vec;
    logic [8:0]          score_sum;
    logic [8:0]          miss_sum;

    wam_lfsr u_lfsr (
        .clk_19   (clk_19),
        .rst      (rst),
        .hole_idx (hole_idx)
    );

`ifdef WAM_SPEEDUP_EN
    int life_calc;

    // Uses the score before this cycle's update; score[7:2] never exceeds 63.
    always_comb begin
        life_calc = LIFE_TICKS - int'(score_q[7:2]);
        if (life_calc < LIFE_MIN) begin
            life_calc = LIFE_MIN;
        end
        life_load = LIFE_W'(life_calc);
    end
`else
    // LIFE_MIN never exceeds LIFE_TICKS, so this always resolves to LIFE_TICKS.
    assign life_load = LIFE_W'((LIFE_MIN > LIFE_TICKS) ? LIFE_MIN : LIFE_TICKS);
`endif

    always_comb begin
        state_d   = state_q;
        game_d    = game_q;
        spawn_d   = spawn_q;
        life_d    = life_q;
        holes_d   = holes_q;
        score_d   = score_q;
        miss_d    = miss_q;
        hit_eff   = '0;
        expire    = '0;
        spawn_vec = '0;
        score_sum = '0;
        miss_sum  = '0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                holes_d = '0;
                if (start) begin
                    state_d = ST_RUN;
                    score_d = '0;
                    miss_d  = '0;
                    game_d  = GAME_W'(GAME_TICKS);
                    spawn_d = SPAWN_W'(SPAWN_TICKS);
                    for (int i = 0; i < NUM_HOLES; i++) begin
                        life_d[i] = '0;
                    end
                end
            end

            ST_RUN: begin
                // Hits on dark holes are late qualifier echoes and are dropped.
                hit_eff = hit & holes_q;
                for (int i = 0; i < NUM_HOLES; i++) begin
                    if (holes_q[i]) begin
                        life_d[i] = life_q[i] - LIFE_W'(1);
                        if (!hit[i] && (life_q[i] == LIFE_W'(1))) begin
                            expire[i] = 1'b1;
                        end
                    end
                end

                // Capacity is judged on occupancy before this cycle's clears.
                if (spawn_q == SPAWN_W'(1)) begin
                    spawn_d = SPAWN_W'(SPAWN_TICKS);
                    if (!holes_q[hole_idx] &&
                        (popcount8(holes_q) < 4'(MAX_MOLES))) begin
                        spawn_vec[hole_idx] = 1'b1;
                        life_d[hole_idx]    = life_load;
                    end
                end else begin
                    spawn_d = spawn_q - SPAWN_W'(1);
                end

                holes_d   = (holes_q & ~hit_eff & ~expire) | spawn_vec;
                score_sum = {1'b0, score_q} + {5'b00000, popcount8(hit_eff)};
                score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];

                if (game_q == GAME_W'(1)) begin
                    // Round ends: moles still lit are cleared without a miss.
                    state_d = ST_OVER;
                    holes_d = '0;
                end else begin
                    miss_sum = {1'b0, miss_q} + {5'b00000, popcount8(expire)};
                    miss_d   = miss_sum[8] ? 8'hFF : miss_sum[7:0];
                end
                game_d = game_q - GAME_W'(1);
            end

            default: begin
                state_d = ST_IDLE;
                holes_d = '0;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge clk_19) begin
        if (rst) begin
            state_q <= ST_IDLE;
            game_q  <= '0;
            spawn_q <= '0;
            holes_q <= '0;
            score_q <= '0;
            miss_q  <= '0;
            busy_q  <= 1'b0;
            over_q  <= 1'b0;
            for (int i = 0; i < NUM_HOLES; i++) begin
                life_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            game_q  <= game_d;
            spawn_q <= spawn_d;
            holes_q <= holes_d;
            score_q <= score_d;
            miss_q  <= miss_d;
            busy_q  <= busy_d;
            over_q  <= over_d;
            life_q  <= life_d;
        end
    end

    assign holes = holes_q;
    assign score = score_q;
    assign miss  = miss_q;
    assign busy  = busy_q;
    assign over  = over_q;

endmodule

// File: tb/tb_wam_mole_ctl.sv
// -----------------------------------------------------------------------------
// tb_wam_mole_ctl
// Directed round sequence with randomized hit patterns, checked every cycle
// against a behavioural game model kept in integer/array form.
// -----------------------------------------------------------------------------
module tb_wam_mole_ctl;

    localparam int LIFE_T  = 6;
    localparam int SPAWN_T = 4;
    localparam int GAME_T  = 40;
    localparam int MAXM    = 2;
    localparam int LMIN    = 3;

    logic       clk_19 = 1'b0;
    logic       rst    = 1'b1;
    logic       start  = 1'b0;
    logic [7:0] hit    = 8'h00;
    logic [7:0] holes, score, miss;
    logic       busy, over;

    int total = 0;
    int bad   = 0;

    always #5 clk_19 = ~clk_19;

    wam_mole_ctl #(
        .LIFE_TICKS  (LIFE_T),
        .LIFE_MIN    (LMIN),
        .SPAWN_TICKS (SPAWN_T),
        .GAME_TICKS  (GAME_T),
        .MAX_MOLES   (MAXM)
    ) dut (
        .clk_19 (clk_19),
        .rst    (rst),
        .start  (start),
        .hit    (hit),
        .holes  (holes),
        .score  (score),
        .miss   (miss),
        .busy   (busy),
        .over   (over)
    );

    // Behavioural model: phase 0 idle, 1 run, 2 over.
    int         m_phase = 0;
    int         m_game  = 0;
    int         m_spawn = 0;
    int         m_score = 0;
    int         m_miss  = 0;
    logic [7:0] m_lit     = 8'h00;
    logic [7:0] m_lfsr    = 8'hA5;
    logic [7:0] m_expired = 8'h00;
    int         m_life     [8];
    int         m_life_set [8];

    // Observation monitors
    int         cyc_no = 0;
    logic [7:0] prev_holes = 8'h00;
    logic       prev_busy  = 1'b0;
    logic       prev_over  = 1'b0;
    int         run_cnt    = 0;
    bit         first_pending = 1'b0;
    int         rise_cyc [8];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lifetime(input int sc);
`ifdef WAM_SPEEDUP_EN
        int l;
        l = LIFE_T - sc / 4;
        return (l < LMIN) ? LMIN : l;
`else
        return LIFE_T;
`endif
    endfunction

    task automatic model_step(input logic st, input logic [7:0] h, input logic r);
        logic [7:0] nxt;
        logic [7:0] lf_next;
        int hc;
        int ec;
        int cand;
        lf_next   = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        m_expired = 8'h00;
        if (r) begin
            m_phase = 0; m_lit = 8'h00; m_score = 0; m_miss = 0;
            m_game = 0; m_spawn = 0; m_lfsr = 8'hA5;
            return;
        end
        if (m_phase != 1) begin
            if (st) begin
                m_phase = 1; m_score = 0; m_miss = 0;
                m_game = GAME_T; m_spawn = SPAWN_T;
            end
        end else begin
            hc  = 0;
            ec  = 0;
            nxt = m_lit;
            for (int i = 0; i < 8; i++) begin
                if (m_lit[i]) begin
                    if (h[i]) begin
                        hc++; nxt[i] = 1'b0;
                    end else if (m_life[i] == 1) begin
                        ec++; nxt[i] = 1'b0; m_expired[i] = 1'b1;
                    end else begin
                        m_life[i]--;
                    end
                end
            end
            if (m_spawn == 1) begin
                m_spawn = SPAWN_T;
                cand = int'(m_lfsr[2:0]);
                if (!m_lit[cand] && ($countones(m_lit) < MAXM)) begin
                    nxt[cand]        = 1'b1;
                    m_life[cand]     = lifetime(m_score);
                    m_life_set[cand] = m_life[cand];
                end
            end else begin
                m_spawn--;
            end
            m_score = (m_score + hc > 255) ? 255 : m_score + hc;
            if (m_game == 1) begin
                m_phase   = 2;
                nxt       = 8'h00;
                m_expired = 8'h00;
            end else begin
                m_miss = (m_miss + ec > 255) ? 255 : m_miss + ec;
            end
            m_game--;
            m_lit = nxt;
        end
        m_lfsr = lf_next;
    endtask

    task automatic cycle(input logic st, input logic [7:0] h, input logic r);
        start = st;
        hit   = h;
        rst   = r;
        @(posedge clk_19);
        model_step(st, h, r);
        @(negedge clk_19);
        cyc_no++;
        chk("holes", holes, m_lit);
        chk("score", score, 8'(m_score));
        chk("miss",  miss,  8'(m_miss));
        chk("busy",  {7'b0, busy}, (m_phase == 1) ? 8'd1 : 8'd0);
        chk("over",  {7'b0, over}, (m_phase == 2) ? 8'd1 : 8'd0);
        chk("capacity", ($countones(holes) > MAXM) ? 8'd1 : 8'd0, 8'd0);

        if (busy && !prev_busy) begin
            run_cnt = 1;
            first_pending = 1'b1;
        end else if (busy) begin
            run_cnt++;
        end
        if (first_pending && (holes != 8'h00)) begin
            chk("first_spawn", 8'(run_cnt - 1), 8'(SPAWN_T));
            first_pending = 1'b0;
        end
        if (!busy) first_pending = 1'b0;
        if (over && !prev_over && prev_busy) begin
            chk("run_len", 8'(run_cnt), 8'(GAME_T));
        end

        for (int i = 0; i < 8; i++) begin
            if (holes[i] && !prev_holes[i]) rise_cyc[i] = cyc_no;
            if (m_expired[i]) chk("lifetime", 8'(cyc_no - rise_cyc[i]), 8'(m_life_set[i]));
        end

        prev_holes = holes;
        prev_busy  = busy;
        prev_over  = over;
    endtask

    // 0 none, 1 hit on first lit cycle, 2 hit on expiry cycle,
    // 3 random on any hole, 4 random on dark holes only
    function automatic logic [7:0] pick_hit(input int mode);
        logic [7:0] h;
        h = 8'h00;
        for (int i = 0; i < 8; i++) begin
            case (mode)
                1: h[i] = m_lit[i] && (m_life[i] == m_life_set[i]);
                2: h[i] = m_lit[i] && (m_life[i] == 1);
                3: h[i] = ($urandom_range(0, 3) == 0);
                4: h[i] = !m_lit[i] && ($urandom_range(0, 1) == 1);
                default: h[i] = 1'b0;
            endcase
        end
        return h;
    endfunction

    task automatic run(input int n, input int mode, input logic st);
        for (int k = 0; k < n; k++) begin
            cycle(st, pick_hit(mode), 1'b0);
        end
    endtask

    initial begin
        @(negedge clk_19);

        // Reset, then idle with stray hits
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        chk("rst_holes", holes, 8'h00);
        chk("rst_score", score, 8'h00);
        chk("rst_miss",  miss,  8'h00);
        chk("rst_busy",  {7'b0, busy}, 8'h00);
        chk("rst_over",  {7'b0, over}, 8'h00);
        for (int k = 0; k < 20; k++) cycle(1'b0, 8'($urandom), 1'b0);

        // Round A: no hits, all moles expire
        cycle(1'b1, 8'h00, 1'b0);
        run(44, 0, 1'b0);

        // Round B from OVER: immediate hits, expiry-cycle hits with start held, dark-hole hits
        cycle(1'b1, 8'h00, 1'b0);
        run(12, 1, 1'b0);
        run(12, 2, 1'b1);
        run(20, 4, 1'b0);

        // Round C: reset at RUN cycle 20
        cycle(1'b1, 8'h00, 1'b0);
        run(19, 3, 1'b0);
        cycle(1'b0, 8'($urandom), 1'b1);
        chk("midrst_holes", holes, 8'h00);
        chk("midrst_score", score, 8'h00);
        chk("midrst_miss",  miss,  8'h00);
        chk("midrst_busy",  {7'b0, busy}, 8'h00);
        run(3, 0, 1'b0);

        // Round D: random hits anywhere
        cycle(1'b1, 8'h00, 1'b0);
        run(44, 3, 1'b0);

        // Round E: hit every mole at once, score climbs through the round
        cycle(1'b1, 8'h00, 1'b0);
        run(44, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
